// File: rtl/dot_weight_loader.sv
// Weight-matrix loader: assembles an AXI4-Stream frame in a shadow buffer and
// commits it atomically to the active weights once the dot datapath is idle.
module dot_weight_loader #(
  parameter int ROWS = 3,
  parameter int COLS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] WEIGHT_AXIS_TDATA,
  input  logic        WEIGHT_AXIS_TLAST,
  input  logic        WEIGHT_AXIS_TVALID,
  output logic        WEIGHT_AXIS_TREADY,
  input  logic        dot_idle,
  input  logic        err_clr,
  output logic [31:0] weights [0:ROWS-1][0:COLS-1],
  output logic        weights_valid,
  output logic        load_err,
  output logic [7:0]  load_count
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {ST_LOAD, ST_DRAIN, ST_COMMIT} state_t;

  state_t          r_state;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [31:0]     r_shadow [0:ROWS-1][0:COLS-1];

  logic w_hs;
  logic w_last_word;

  // Ready is a pure state decode; rst gating keeps it low while reset is held.
  assign WEIGHT_AXIS_TREADY = !rst && (r_state != ST_COMMIT);
  assign w_hs        = WEIGHT_AXIS_TVALID && WEIGHT_AXIS_TREADY;
  assign w_last_word = (r_row == RW'(ROWS-1)) && (r_col == CW'(COLS-1));

  // Shadow needs no reset: every entry is rewritten before any commit.
  always_ff @(posedge clk) begin
    if (w_hs && r_state == ST_LOAD)
      r_shadow[r_row][r_col] <= WEIGHT_AXIS_TDATA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_LOAD;
      r_row         <= '0;
      r_col         <= '0;
      weights_valid <= 1'b0;
      load_err      <= 1'b0;
      load_count    <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          weights[r][c] <= '0;
    end else begin
      if (err_clr) load_err <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_hs) begin
            if (w_last_word) begin
              r_row <= '0;
              r_col <= '0;
              if (WEIGHT_AXIS_TLAST) begin
                r_state <= ST_COMMIT;
              end else begin
                r_state  <= ST_DRAIN;
                load_err <= 1'b1;
              end
            end else if (WEIGHT_AXIS_TLAST) begin
              // Short frame: drop it and restart at index 0.
              load_err <= 1'b1;
              r_row    <= '0;
              r_col    <= '0;
            end else if (r_col == CW'(COLS-1)) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_hs && WEIGHT_AXIS_TLAST) begin
            r_state <= ST_LOAD;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        ST_COMMIT: begin
          if (dot_idle) begin
            for (int r = 0; r < ROWS; r++)
              for (int c = 0; c < COLS; c++)
                weights[r][c] <= r_shadow[r][c];
            weights_valid <= 1'b1;
            load_count    <= load_count + 8'd1;
            r_row         <= '0;
            r_col         <= '0;
            r_state       <= ST_LOAD;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_weight_loader.sv
// Directed bench for dot_weight_loader (ROWS=3, COLS=4) with hand-computed expectations.
module tb_dot_weight_loader;
  localparam int ROWS = 3;
  localparam int COLS = 4;
  localparam int N    = ROWS * COLS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tdata = '0;
  logic        tlast = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        dot_idle = 1'b1;
  logic        err_clr = 1'b0;
  logic [31:0] weights [0:ROWS-1][0:COLS-1];
  logic        weights_valid;
  logic        load_err;
  logic [7:0]  load_count;

  logic [31:0] exp_w [0:ROWS-1][0:COLS-1];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dot_weight_loader #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst),
    .WEIGHT_AXIS_TDATA(tdata), .WEIGHT_AXIS_TLAST(tlast),
    .WEIGHT_AXIS_TVALID(tvalid), .WEIGHT_AXIS_TREADY(tready),
    .dot_idle(dot_idle), .err_clr(err_clr),
    .weights(weights), .weights_valid(weights_valid),
    .load_err(load_err), .load_count(load_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_weights(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        chk($sformatf("%s_w%0d%0d", tag, r, c), weights[r][c], exp_w[r][c]);
  endtask

  task automatic set_exp(input int base);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        exp_w[r][c] = base + r*COLS + c + 1;
  endtask

  // Sends n words base+1..base+n back to back; TLAST on word last_at (0 = none).
  task automatic send(input int base, input int n, input int last_at);
    for (int k = 1; k <= n; k++) begin
      tvalid = 1'b1;
      tdata  = base + k;
      tlast  = (k == last_at);
      tick();
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  initial begin
    int got;
    int iter;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        exp_w[r][c] = '0;

    // Reset state
    tick();
    chk("rst_tready", tready, 0);
    chk("rst_valid", weights_valid, 0);
    chk("rst_count", load_count, 0);
    chk("rst_err", load_err, 0);
    chk_weights("rst");
    rst = 1'b0;
    #1;
    chk("post_rst_tready", tready, 1);

    // Good frame A: 1..12, commit one edge after the last handshake
    send(0, N, N);
    chk("A_commit_tready", tready, 0);
    chk("A_pre_valid", weights_valid, 0);
    chk("A_pre_count", load_count, 0);
    tick();
    set_exp(0);
    chk("A_tready_back", tready, 1);
    chk("A_valid", weights_valid, 1);
    chk("A_count", load_count, 1);
    chk("A_w00", weights[0][0], 1);
    chk("A_w10", weights[1][0], 5);
    chk("A_w23", weights[2][3], 12);
    chk_weights("A");

    // Early TLAST on word 5
    send(100, 5, 5);
    chk("early_err", load_err, 1);
    chk("early_tready", tready, 1);
    chk("early_count", load_count, 1);
    chk_weights("early");

    // Frame B loads from index 0 after the short frame
    send(200, N, N);
    chk_weights("B_pre");
    chk("B_pre_count", load_count, 1);
    tick();
    set_exp(200);
    chk_weights("B");
    chk("B_count", load_count, 2);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr1_err", load_err, 0);

    // Missing TLAST: error at word 12, words 13-14 drained
    send(300, N, 0);
    chk("miss_err12", load_err, 1);
    chk("miss_drain_tready", tready, 1);
    send(312, 2, 2);
    chk("miss_tready", tready, 1);
    tick();
    chk("miss_count", load_count, 2);
    chk_weights("miss");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr2_err", load_err, 0);

    // Datapath busy for 5 cycles after the last word
    dot_idle = 1'b0;
    send(400, N, N);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("busy_tready%0d", i), tready, 0);
      chk($sformatf("busy_count%0d", i), load_count, 2);
      tick();
    end
    chk_weights("busy");
    dot_idle = 1'b1;
    #1;
    chk("busy_idle_tready", tready, 0);
    tick();
    set_exp(400);
    chk_weights("C");
    chk("C_count", load_count, 3);
    chk("C_tready", tready, 1);
    dot_idle = 1'b0;
    tick();
    chk("C_idle_drop_count", load_count, 3);
    dot_idle = 1'b1;

    // Backpressure: random TVALID, data changes every cycle
    got = 0;
    iter = 0;
    while (got < N && iter < 400) begin
      tvalid = $urandom_range(0, 1);
      tdata  = $urandom;
      tlast  = tvalid && (got == N-1);
      if (tvalid) begin
        exp_w[got / COLS][got % COLS] = tdata;
        got++;
      end
      tick();
      iter++;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = 32'hdead_beef;
    chk("bp_words", got, N);
    tick();
    chk_weights("bp");
    chk("bp_count", load_count, 4);

    // Reset mid-frame after 6 words, asserted between edges
    send(500, 6, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tready", tready, 0);
    chk("mid_rst_valid", weights_valid, 0);
    chk("mid_rst_count", load_count, 0);
    chk("mid_rst_err", load_err, 0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        exp_w[r][c] = '0;
    chk_weights("mid_rst");
    tick();
    rst = 1'b0;
    send(600, N, N);
    tick();
    set_exp(600);
    chk_weights("fresh");
    chk("fresh_count", load_count, 1);
    chk("fresh_valid", weights_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
